inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
// - IF stage: owns the PC and fetches 32-bit instructions from the memory controller.
// - Optionally serves fetches from a direct-mapped instruction cache.
// - Drives if_pc/if_inst into the IF/ID register.
// - Raises stallreq_if while the instruction at the PC is not yet available.
// - Redirects the PC on an EX-stage jump.
// PARAMETERS
// - RESET_PC      32'h0  PC value after reset
// - ICACHE_LINES  128    cache lines, one word each, power of 2; IDX = log2(ICACHE_LINES)
// PORTS
// - clk           in   1   clock, single domain
// - rst           in   1   synchronous, active-high reset
// - rdy           in   1   global ready; 0 freezes all state
// - stall         in   6   pipeline stall vector; bit0 holds the PC
// - ifjump        in   1   EX redirect this cycle
// - jump_pc       in   32  redirect target (word-aligned)
// - if_pc         out  32  current PC (== pc register)
// - if_inst       out  32  instruction at if_pc; 0 when unavailable
// - stallreq_if   out  1   1 = if_inst is not valid this cycle
// - mem_req       out  1   fetch request to the memory controller
// - mem_addr      out  32  fetch address
// - mem_done      in   1   one-cycle pulse: mem_inst is valid
// - mem_inst      in   32  fetched word
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=IDLE, buf_valid=0, discard=0, mem_req=0, mem_addr=0, all cache valid bits=0.
// - rdy=0: no register changes. mem_req/mem_addr hold their values.
// - Availability:
//   - avail = buf_valid | hit.
//   - if_inst = buf_valid ? inst_buf : hit ? cache_data[idx] : 0.
//   - stallreq_if = ~avail.
//   - Purely combinational from registers. Never depends on stall, so no loop through ctrl.
// - FSM IDLE:
//   - If ~avail & ~ifjump: next cycle mem_req=1, mem_addr=pc, req_addr=pc, state=WAIT.
//   - Miss latency: mem_req rises 1 cycle after the miss; if_inst is valid 1 cycle after mem_done.
// - FSM WAIT:
//   - mem_req and mem_addr are held until mem_done.
//   - On mem_done: mem_req=0, state=IDLE.
//   - If discard=0: inst_buf=mem_inst, buf_valid=1.
//   - If discard=1: drop the data, discard=0.
// - Advance: if avail & ~stall[0] & ~ifjump: pc=pc+4 (wraps mod 2^32), buf_valid=0.
// - Redirect (ifjump=1), takes priority over advance and stall[0]:
//   - pc=jump_pc, buf_valid=0.
//   - If in WAIT without mem_done this cycle: discard=1.
//   - If mem_done arrives the same cycle as ifjump: drop the data, discard stays 0.
//   - A new request for jump_pc is issued only after returning to IDLE. An outstanding request is never aborted.
// - Stall: stall[0]=1 & ~ifjump holds pc and buf_valid. A fetch may still complete into the buffer.
// - At most one request is outstanding. mem_req is never asserted while in WAIT for another address.
// CONFIGURATION
// - ICACHE_EN defined:
//   - Direct-mapped cache: idx = pc[IDX+1:2], tag = pc[31:IDX+2], hit = valid[idx] & tag match.
//   - Fill on every mem_done at req_addr, including discarded responses.
//   - A hit makes if_inst valid in the same cycle with no memory request. Consecutive hits advance 1 PC per cycle.
// - ICACHE_EN undefined:
//   - hit = 0; no cache storage is built; ICACHE_LINES is unused.
//   - Every PC is fetched from memory, costing at least 3 cycles per instruction.
// TESTING
// - T1 reset: rst=1 for 2 cycles -> if_pc=0, if_inst=0, stallreq_if=1, mem_req=0.
//   - Next cycle: mem_req=1, mem_addr=0.
// - T2 miss: mem_done pulse with mem_inst=32'h00100093 after 3 cycles.
//   - Next cycle: if_inst=32'h00100093, stallreq_if=0.
//   - Following cycle: if_pc=4.
// - T3 stall: with an instruction available, hold stall[0]=1 for 4 cycles.
//   - if_pc stays 4 and if_inst is stable.
//   - On release, pc advances to 8 in 1 cycle.
// - T4 jump during WAIT: ifjump=1, jump_pc=32'h100 while waiting on addr 8.
//   - Later mem_done with 32'hDEADBEEF is ignored and if_inst stays 0.
//   - New mem_req issued with mem_addr=32'h100.
// - T5 ICACHE_EN: run a loop 0x0..0xC twice.
//   - Second pass: no mem_req, stallreq_if=0, pc advances every cycle.
//   - Without ICACHE_EN: the second pass re-fetches all 4 words.
// - T6 rdy=0 mid-WAIT for 3 cycles:
//   - pc, state and mem_req frozen.
//   - On resume, the pending mem_done is accepted normally.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage.
// Owns the PC, fetches 32-bit words from the memory controller (one request
// outstanding at most), and presents if_pc/if_inst to the IF/ID register.
// Optional direct-mapped one-word-per-line instruction cache, enabled by
// defining the macro ICACHE_EN.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   rdy             global ready; 0 freezes every register
//   stall[5:0]      pipeline stall vector; only bit 0 (hold PC) is used here
//   ifjump, jump_pc EX-stage redirect request and target
//   if_pc, if_inst  current PC and its instruction (0 when unavailable)
//   stallreq_if     1 while if_inst is not valid
//   mem_req/addr    fetch request to memory controller
//   mem_done/inst   one-cycle response pulse and fetched word
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ICACHE_LINES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [5:0]  stall,
    input  logic        ifjump,
    input  logic [31:0] jump_pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_inst
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic        buf_valid;
    logic        discard;
    logic        hit;
    logic        avail;
    logic [31:0] cache_word;

    // Only the PC-hold bit of the stall vector matters to this stage.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[5:1]};

`ifdef ICACHE_EN
    localparam int unsigned IDX  = $clog2(ICACHE_LINES);
    localparam int unsigned TAGW = 30 - IDX;

    logic [31:2]             req_addr;
    logic [ICACHE_LINES-1:0] cache_valid;
    logic [TAGW-1:0]         cache_tag  [ICACHE_LINES];
    logic [31:0]             cache_data [ICACHE_LINES];
    logic [IDX-1:0]          idx;
    logic [IDX-1:0]          fill_idx;
    logic                    fill;

    assign idx        = pc[IDX+1:2];
    assign fill_idx   = req_addr[IDX+1:2];
    assign hit        = cache_valid[idx] & (cache_tag[idx] == pc[31:IDX+2]);
    assign cache_word = cache_data[idx];
    // Every response fills, including ones the pipeline drops after a redirect.
    assign fill       = rdy & (state == S_WAIT) & mem_done;

    // Valid bits: the only cache state that needs a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= '0;
        end else if (fill) begin
            cache_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage.
    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            cache_tag[fill_idx]  <= req_addr[31:IDX+2];
            cache_data[fill_idx] <= mem_inst;
        end
    end
`else
    localparam int unsigned unused_lines = ICACHE_LINES;

    assign hit        = 1'b0;
    assign cache_word = 32'h0;
`endif

    // Availability and outputs, purely from registers (no path from stall).
    assign avail       = buf_valid | hit;
    assign if_pc       = pc;
    assign if_inst     = buf_valid ? inst_buf : (hit ? cache_word : 32'h0);
    assign stallreq_if = ~avail;

    // PC, fetch FSM and response buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            inst_buf  <= 32'h0;
            buf_valid <= 1'b0;
            discard   <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0;
`ifdef ICACHE_EN
            req_addr  <= '0;
`endif
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (!avail && !ifjump) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
`ifdef ICACHE_EN
                        req_addr <= pc[31:2];
`endif
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                        discard <= 1'b0;
                        // Keep the word only if no redirect happened since the request.
                        if (!discard && !ifjump) begin
                            inst_buf  <= mem_inst;
                            buf_valid <= 1'b1;
                        end
                    end else if (ifjump) begin
                        // Outstanding request is never aborted; its data is dropped later.
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Redirect beats both advance and stall.
            if (ifjump) begin
                pc        <= jump_pc;
                buf_valid <= 1'b0;
            end else if (avail && !stall[0]) begin
                pc        <= pc + 32'd4;
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: reset, miss, stall, redirect during a
// fetch, redirect coinciding with a response, rdy freeze and a 4-word loop.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [5:0]  stall;
    logic        ifjump;
    logic [31:0] jump_pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_inst;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .stall      (stall),
        .ifjump     (ifjump),
        .jump_pc    (jump_pc),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .stallreq_if(stallreq_if),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_inst   (mem_inst)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] loop_word(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; stall = 6'b0; ifjump = 1'b0; jump_pc = 32'h0;
        mem_done = 1'b0; mem_inst = 32'h0;
        step(); step();
        rst = 1'b0;
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=%h", if_pc, 32'h0); end
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h want=%h", if_inst, 32'h0); end
        checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL reset_stallreq got=%b want=1", stallreq_if); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_memreq got=%b want=0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL first_req req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_miss();
        logic [31:0] exp;
        step(); step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || stallreq_if !== 1'b1) begin
            failures++; $display("FAIL miss_hold req=%b addr=%h stallreq=%b want 1/0/1", mem_req, mem_addr, stallreq_if);
        end
        mem_done = 1'b1; mem_inst = 32'h00100093; exp_q.push_back(mem_inst);
        step();
        mem_done = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (if_inst !== exp || stallreq_if !== 1'b0) begin
            failures++; $display("FAIL miss_data inst=%h stallreq=%b want inst=%h stallreq=0", if_inst, stallreq_if, exp);
        end
        checks++; if (if_pc !== 32'h0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL miss_state pc=%h req=%b want pc=0 req=0", if_pc, mem_req);
        end
        step();
        checks++; if (if_pc !== 32'h4 || stallreq_if !== 1'b1) begin
            failures++; $display("FAIL miss_advance pc=%h stallreq=%b want pc=4 stallreq=1", if_pc, stallreq_if);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            failures++; $display("FAIL stall_req req=%b addr=%h want req=1 addr=4", mem_req, mem_addr);
        end
        mem_done = 1'b1; mem_inst = 32'h00200113; exp_q.push_back(mem_inst);
        step();
        mem_done = 1'b0; stall = 6'b000001;
        exp = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (if_pc !== 32'h4 || if_inst !== exp || stallreq_if !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d pc=%h inst=%h stallreq=%b req=%b want pc=4 inst=%h stallreq=0 req=0",
                         i, if_pc, if_inst, stallreq_if, mem_req, exp);
            end
        end
        stall = 6'b0;
        step();
        checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL stall_release pc=%h want=%h", if_pc, 32'h8); end
    endtask

    task automatic test_jump_wait();
        logic [31:0] exp;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            failures++; $display("FAIL jump_req8 req=%b addr=%h want req=1 addr=8", mem_req, mem_addr);
        end
        ifjump = 1'b1; jump_pc = 32'h100;
        step();
        ifjump = 1'b0;
        checks++; if (if_pc !== 32'h100 || mem_req !== 1'b1 || mem_addr !== 32'h8 || if_inst !== 32'h0) begin
            failures++; $display("FAIL jump_redirect pc=%h req=%b addr=%h inst=%h want pc=100 req=1 addr=8 inst=0",
                                 if_pc, mem_req, mem_addr, if_inst);
        end
        step();
        mem_done = 1'b1; mem_inst = 32'hDEADBEEF;
        step();
        mem_done = 1'b0;
        checks++; if (if_inst !== 32'h0 || stallreq_if !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL jump_discard inst=%h stallreq=%b req=%b want inst=0 stallreq=1 req=0",
                                 if_inst, stallreq_if, mem_req);
        end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            failures++; $display("FAIL jump_newreq req=%b addr=%h want req=1 addr=100", mem_req, mem_addr);
        end
        mem_done = 1'b1; mem_inst = 32'h00000513; exp_q.push_back(mem_inst);
        step();
        mem_done = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (if_inst !== exp || if_pc !== 32'h100) begin
            failures++; $display("FAIL jump_target inst=%h pc=%h want inst=%h pc=100", if_inst, if_pc, exp);
        end
    endtask

    task automatic test_rdy();
        logic [31:0] exp;
        step();
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || if_pc !== 32'h104) begin
            failures++; $display("FAIL rdy_req req=%b addr=%h pc=%h want 1/104/104", mem_req, mem_addr, if_pc);
        end
        rdy = 1'b0; ifjump = 1'b1; jump_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_pc !== 32'h104 || mem_req !== 1'b1 || mem_addr !== 32'h104 || stallreq_if !== 1'b1) begin
                failures++; $display("FAIL rdy_freeze cyc=%0d pc=%h req=%b addr=%h stallreq=%b want 104/1/104/1",
                                     i, if_pc, mem_req, mem_addr, stallreq_if);
            end
        end
        rdy = 1'b1; ifjump = 1'b0;
        step();
        mem_done = 1'b1; mem_inst = 32'h00100513; exp_q.push_back(mem_inst);
        step();
        mem_done = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (if_inst !== exp || if_pc !== 32'h104 || stallreq_if !== 1'b0) begin
            failures++; $display("FAIL rdy_resume inst=%h pc=%h stallreq=%b want inst=%h pc=104 stallreq=0",
                                 if_inst, if_pc, stallreq_if, exp);
        end
    endtask

    task automatic test_jump_done();
        logic [31:0] exp;
        step();
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin
            failures++; $display("FAIL jd_req req=%b addr=%h want req=1 addr=108", mem_req, mem_addr);
        end
        ifjump = 1'b1; jump_pc = 32'h300; mem_done = 1'b1; mem_inst = 32'h00000BAD;
        step();
        ifjump = 1'b0; mem_done = 1'b0;
        checks++; if (if_pc !== 32'h300 || if_inst !== 32'h0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL jd_drop pc=%h inst=%h req=%b want pc=300 inst=0 req=0", if_pc, if_inst, mem_req);
        end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            failures++; $display("FAIL jd_newreq req=%b addr=%h want req=1 addr=300", mem_req, mem_addr);
        end
        mem_done = 1'b1; mem_inst = 32'h00000011; exp_q.push_back(mem_inst);
        step();
        mem_done = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (if_inst !== exp || stallreq_if !== 1'b0) begin
            failures++; $display("FAIL jd_accept inst=%h stallreq=%b want inst=%h stallreq=0", if_inst, stallreq_if, exp);
        end
    endtask

    task automatic test_loop();
        logic [31:0] pc_exp;
        logic [31:0] exp;
        int          budget;
        int          reqs;
        int          reqs_exp;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            reqs = 0;
            for (int k = 0; k < 4; k++) begin
                pc_exp = 32'(k * 4);
`ifdef ICACHE_EN
                if (pass == 1) begin
                    checks++; if (stallreq_if !== 1'b0 || mem_req !== 1'b0 || if_pc !== pc_exp ||
                                  if_inst !== loop_word(pc_exp)) begin
                        failures++; $display("FAIL loop_hit k=%0d pc=%h inst=%h stallreq=%b req=%b want pc=%h inst=%h",
                                             k, if_pc, if_inst, stallreq_if, mem_req, pc_exp, loop_word(pc_exp));
                    end
                    step();
                    continue;
                end
`endif
                budget = 0;
                while (mem_req !== 1'b1 && budget < 8) begin
                    step();
                    budget++;
                end
                checks++; if (mem_req !== 1'b1 || mem_addr !== pc_exp) begin
                    failures++; $display("FAIL loop_req pass=%0d k=%0d req=%b addr=%h want req=1 addr=%h",
                                         pass, k, mem_req, mem_addr, pc_exp);
                end
                if (mem_req === 1'b1) reqs++;
                mem_done = 1'b1; mem_inst = loop_word(pc_exp); exp_q.push_back(mem_inst);
                step();
                mem_done = 1'b0;
                exp = exp_q.pop_front();
                checks++; if (if_inst !== exp || if_pc !== pc_exp || stallreq_if !== 1'b0) begin
                    failures++; $display("FAIL loop_fetch pass=%0d k=%0d inst=%h pc=%h stallreq=%b want inst=%h pc=%h",
                                         pass, k, if_inst, if_pc, stallreq_if, exp, pc_exp);
                end
                if (k == 3 && pass == 0) begin
                    ifjump = 1'b1; jump_pc = 32'h0;
                    step();
                    ifjump = 1'b0;
                end else begin
                    step();
                end
            end
            if (pass == 1) begin
`ifdef ICACHE_EN
                reqs_exp = 0;
`else
                reqs_exp = 4;
`endif
                checks++; if (reqs !== reqs_exp) begin
                    failures++; $display("FAIL loop_refetch reqs=%0d want=%0d", reqs, reqs_exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_miss();
        test_stall();
        test_jump_wait();
        test_rdy();
        test_jump_done();
        test_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
